// File: rtl/iot_extremum_filter.sv
// -----------------------------------------------------------------------------
// iot_extremum_filter
//
// Streaming extremum filter. Narrow IN_W-bit slices arrive MSB slice first and
// are assembled into DATA_W-bit words. Over a group of GROUP words the block
// tracks either the largest (mode=0) or the smallest (mode=1) word, using an
// unsigned strict comparison so that the earliest word wins on ties. When the
// last slice of the last word is accepted, the winner and its in-group index
// are presented with a one-cycle out_valid pulse and held until the next
// result.
//
// Parameters
//   DATA_W  word width (multiple of IN_W, and at least 2*IN_W)
//   IN_W    slice width
//   GROUP   words per group (>= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_en      slice valid; iot_in accepted when high
//   iot_in     data slice, MSB slice of each word first
//   mode       0 = max, 1 = min; sampled on the first slice of word 0
//   clear      synchronous abort of the partial group (wins over in_en)
//   busy       high while a group is partially received
//   out_valid  one-cycle result pulse
//   out_data   winning word of the last completed group
//   out_idx    index of the winning word within its group
// -----------------------------------------------------------------------------
module iot_extremum_filter #(
    parameter int DATA_W = 128,
    parameter int IN_W   = 8,
    parameter int GROUP  = 8,
    localparam int SLICES = DATA_W / IN_W,
    localparam int IDX_W  = $clog2(GROUP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [IN_W-1:0]   iot_in,
    input  logic              mode,
    input  logic              clear,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx
);

    localparam int SCNT_W = $clog2(SLICES);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [SCNT_W-1:0]      slice_cnt_reg;
    logic [IDX_W-1:0]       word_cnt_reg;
    // Only the lower DATA_W-IN_W bits are ever needed: the top slice of the
    // previous word is shifted out by the time a word completes.
    logic [DATA_W-IN_W-1:0] shift_reg;
    logic [DATA_W-1:0]      best_reg;
    logic [IDX_W-1:0]       best_idx_reg;
    logic                   mode_reg;
    logic                   out_valid_reg;
    logic [DATA_W-1:0]      out_data_reg;
    logic [IDX_W-1:0]       out_idx_reg;

    logic                   accept;
    logic                   last_slice;
    logic                   first_slice;
    logic                   first_word;
    logic                   last_word;
    logic                   word_done;
    logic                   group_done;
    logic [DATA_W-1:0]      candidate;
    logic                   take;

    // clear has priority: a slice presented together with clear is dropped.
    assign accept      = in_en & ~clear;
    assign first_slice = (slice_cnt_reg == '0);
    assign last_slice  = (slice_cnt_reg == SCNT_W'(SLICES - 1));
    assign first_word  = (word_cnt_reg == '0);
    assign last_word   = (word_cnt_reg == IDX_W'(GROUP - 1));
    assign word_done   = accept & last_slice;
    assign group_done  = word_done & last_word;

    // Full word as it stands once the current slice is appended; on the last
    // slice this is the completed word, otherwise it is the next shift value.
    assign candidate = {shift_reg, iot_in};

    // Word 0 always loads; later words replace only on a strict improvement.
    assign take = first_word |
                  (mode_reg ? (candidate < best_reg) : (candidate > best_reg));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                if (clear || group_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_cnt_reg <= '0;
            word_cnt_reg  <= '0;
        end else if (clear) begin
            slice_cnt_reg <= '0;
            word_cnt_reg  <= '0;
        end else if (accept) begin
            if (last_slice) begin
                slice_cnt_reg <= '0;
                word_cnt_reg  <= last_word ? '0 : word_cnt_reg + IDX_W'(1);
            end else begin
                slice_cnt_reg <= slice_cnt_reg + SCNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            best_reg     <= '0;
            best_idx_reg <= '0;
            mode_reg     <= 1'b0;
        end else if (accept) begin
            shift_reg <= candidate[DATA_W-IN_W-1:0];
            // Direction is fixed for the whole group once word 0 starts.
            if (first_slice && first_word) begin
                mode_reg <= mode;
            end
            if (last_slice && take) begin
                best_reg     <= candidate;
                best_idx_reg <= word_cnt_reg;
            end
        end
    end

    // --------------------------------------------------------------- result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
        end else begin
            out_valid_reg <= group_done;
            // The final word is judged in the same cycle it completes, so the
            // result comes from the comparison rather than from best_reg.
            if (group_done) begin
                out_data_reg <= take ? candidate : best_reg;
                out_idx_reg  <= take ? word_cnt_reg : best_idx_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;

endmodule
